// File: rtl/rv_enc_pkg.sv
// Shared constants for the RV32I field encoder: format codes, decoder opcodes, NOP and FSM states.
// The optional range checking in rv_instr_pack is enabled by defining RV_ENC_RANGE_CHECK_EN.
package rv_enc_pkg;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_e;

  // slli/srli/srai carry funct7 in the upper immediate bits and a 5-bit shamt
  function automatic logic is_imm_shift(input logic [4:0] opcode, input logic [2:0] funct3);
    return (opcode == OP_IMM[6:2]) && (funct3[1:0] == 2'b01);
  endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I packer: decoded fields to a 32-bit word plus an encoding-error flag.
// Defining RV_ENC_RANGE_CHECK_EN adds immediate range checks; otherwise fields truncate silently.
module rv_instr_pack
  import rv_enc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [4:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        enc_err
);

  logic [6:0] op;
  logic       shift;
  logic       fmt_bad;
  logic       range_err;

  assign op    = {opcode, 2'b11};
  assign shift = is_imm_shift(opcode, funct3);

  always_comb begin
    word    = NOP;
    fmt_bad = 1'b0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, op};
      FMT_I: begin
        if (shift) word = {funct7, imm[4:0], rs1, funct3, rd, op};
        else       word = {imm[11:0], rs1, funct3, rd, op};
      end
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
      FMT_U: word = {imm[31:12], rd, op};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: fmt_bad = 1'b1;
    endcase
  end

`ifdef RV_ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = imm;

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I: begin
        if (shift) range_err = (imm[31:5] != 27'd0);
        else       range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      end
      FMT_S: range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_B: range_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || imm[0];
      FMT_U: range_err = (imm[11:0] != 12'd0);
      FMT_J: range_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || imm[0];
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  assign enc_err = fmt_bad | range_err;

endmodule

// File: rtl/rv_instr_encoder.sv
// Streams decoded RV32I field bundles into consecutive instruction-memory words (one-cycle latency).
// Immediate range checking is compiled in when RV_ENC_RANGE_CHECK_EN is defined.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [1:0]        err
);

  localparam logic [ADDR_W-1:0] BASE_C  = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_reg, state_next;
  logic [ADDR_W:0]   count_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              done_reg;
  logic [1:0]        err_reg;

  logic [31:0]       word;
  logic              enc_err;
  logic              accept;
  logic [ADDR_W:0]   count_inc;
  logic              full;

  rv_instr_pack u_pack (
    .fmt     (in_fmt),
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .word    (word),
    .enc_err (enc_err)
  );

  // count saturates at DEPTH, so its MSB alone means "memory full"; start blocks the handshake
  assign in_ready  = (state_reg == ST_LOAD) && !count_reg[ADDR_W] && !start;
  assign accept    = in_valid && in_ready;
  assign count_inc = count_reg + ONE_C;
  assign full      = (count_inc == DEPTH_C);

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = ST_LOAD;
    end else if (accept && (in_last || full)) begin
      state_next = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= BASE_C;
      mem_wdata_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= '0;
    end else if (start) begin
      // a write already sitting in the output register still completes this cycle
      count_reg  <= '0;
      mem_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= '0;
    end else begin
      mem_we_reg <= accept;
      if (accept) begin
        mem_addr_reg  <= BASE_C + count_reg[ADDR_W-1:0];
        mem_wdata_reg <= word;
        count_reg     <= count_inc;
        if (enc_err)          err_reg[0] <= 1'b1;
        if (full && !in_last) err_reg[1] <= 1'b1;
        if (in_last || full)  done_reg   <= 1'b1;
      end
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign busy      = (state_reg == ST_LOAD);
  assign done      = done_reg;
  assign count     = count_reg;
  assign err       = err_reg;

endmodule
